// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU definitions used by the decode stage.
//   opcode_e  - 5-bit opcode encoding
//   *_MSB/LSB - instruction field positions inside a 16-bit IR
//   LINK_REG  - register written with the return address by CALL/CALLR
//   is_writer - true for opcodes that write a destination register
package cpu_pkg;

   typedef enum logic [4:0] {
      OP_NOP   = 5'h00,
      OP_ADD   = 5'h01,
      OP_SUB   = 5'h02,
      OP_AND   = 5'h03,
      OP_OR    = 5'h04,
      OP_LD    = 5'h05,
      OP_ST    = 5'h06,
      OP_MVI   = 5'h07,
      OP_J     = 5'h08,
      OP_JR    = 5'h09,
      OP_CALL  = 5'h0A,
      OP_CALLR = 5'h0B
   } opcode_e;

   localparam int OP_MSB    = 15;
   localparam int OP_LSB    = 11;
   localparam int RX_MSB    = 10;
   localparam int RX_LSB    = 8;
   localparam int RY_MSB    = 7;
   localparam int RY_LSB    = 5;
   localparam int IMM11_MSB = 10;
   localparam int IMM8_MSB  = 7;

   localparam int LINK_REG  = 7;

   function automatic logic is_writer(input logic [4:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LD, OP_MVI, OP_CALL, OP_CALLR: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: purely combinational field extraction and classification
// of one instruction word.
//   ir        in  - instruction word
//   op/rx/ry  out - opcode and register fields
//   imm8/11   out - sign-extended immediates (DW bits)
//   uses_rx/uses_ry - rx/ry are read as sources
//   writes_rx - instruction writes a register
//   is_sjump/is_rjump - immediate / register-target control transfer
//   issues_ex - instruction produces an operation for execute
//   illegal   - undefined opcode (treated as NOP)
module instr_decoder
   import cpu_pkg::*;
#(
   parameter int IW = 16,
   parameter int DW = 16,
   parameter int RW = 3
) (
   input  logic               [IW-1:0] ir,
   output logic               [4:0]    op,
   output logic               [RW-1:0] rx,
   output logic               [RW-1:0] ry,
   output logic signed        [DW-1:0] imm8,
   output logic signed        [DW-1:0] imm11,
   output logic                        uses_rx,
   output logic                        uses_ry,
   output logic                        writes_rx,
   output logic                        is_sjump,
   output logic                        is_rjump,
   output logic                        issues_ex,
   output logic                        illegal
);

   logic signed [IMM8_MSB:0]  imm8_raw;
   logic signed [IMM11_MSB:0] imm11_raw;

   assign op        = ir[OP_MSB:OP_LSB];
   assign rx        = ir[RX_MSB:RX_LSB];
   assign ry        = ir[RY_MSB:RY_LSB];
   assign imm8_raw  = ir[IMM8_MSB:0];
   assign imm11_raw = ir[IMM11_MSB:0];
   // Signed size casts replicate the sign bit.
   assign imm8      = DW'(imm8_raw);
   assign imm11     = DW'(imm11_raw);
   assign writes_rx = is_writer(op);

   always_comb begin
      uses_rx   = 1'b0;
      uses_ry   = 1'b0;
      is_sjump  = 1'b0;
      is_rjump  = 1'b0;
      issues_ex = 1'b0;
      illegal   = 1'b0;
      case (op)
         OP_NOP: ;
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ST: begin
            uses_rx   = 1'b1;
            uses_ry   = 1'b1;
            issues_ex = 1'b1;
         end
         OP_LD: begin
            uses_ry   = 1'b1;
            issues_ex = 1'b1;
         end
         OP_MVI:   issues_ex = 1'b1;
         OP_J:     is_sjump  = 1'b1;
         OP_JR: begin
            uses_rx  = 1'b1;
            is_rjump = 1'b1;
         end
         OP_CALL: begin
            is_sjump  = 1'b1;
            issues_ex = 1'b1;
         end
         OP_CALLR: begin
            uses_rx   = 1'b1;
            is_rjump  = 1'b1;
            issues_ex = 1'b1;
         end
         default:  illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: decode stage between fetch and execute.
//   clk, reset (sync, active-low)
//   ld_pc_dc/ld_ir_dc, pc_in, ir_in  - instruction offered by fetch
//   ex_ready                         - execute accepts the EX register
//   r_jump/s_jump, jmp_imm, jmp_reg  - jump requests back to fetch
//   dc_stall                         - DC instruction cannot advance
//   ex_valid, ex_op/rx/ry/imm/pc     - EX register toward execute
//   illegal                          - pulse when an undefined opcode advances
//   bubble_cnt                       - saturating count of hazard bubbles
module decode_stage
   import cpu_pkg::*;
#(
   parameter int IW = 16,
   parameter int DW = 16,
   parameter int RW = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ld_pc_dc,
   input  logic          ld_ir_dc,
   input  logic [DW-1:0] pc_in,
   input  logic [IW-1:0] ir_in,
   input  logic          ex_ready,
   output logic          r_jump,
   output logic          s_jump,
   output logic [DW-1:0] jmp_imm,
   output logic [RW-1:0] jmp_reg,
   output logic          dc_stall,
   output logic          ex_valid,
   output logic [4:0]    ex_op,
   output logic [RW-1:0] ex_rx,
   output logic [RW-1:0] ex_ry,
   output logic [DW-1:0] ex_imm,
   output logic [DW-1:0] ex_pc,
   output logic          illegal,
   output logic [15:0]   bubble_cnt
);

   // DC register (stage p0)
   logic          vld_p0;
   logic [DW-1:0] pc_p0;
   logic [IW-1:0] ir_p0;
   // Writer flag of the EX operation, kept alongside the EX register.
   logic          ex_writes;

   logic [4:0]           d_op;
   logic [RW-1:0]        d_rx, d_ry;
   logic signed [DW-1:0] d_imm8, d_imm11;
   logic d_uses_rx, d_uses_ry, d_writes_rx, d_is_sjump, d_is_rjump;
   logic d_issues_ex, d_illegal;

   logic          ld_use, jr_dep, hazard, ex_open, advance, is_call;
   logic [RW-1:0] ex_rx_nxt;
   logic [DW-1:0] ex_imm_nxt;

   // Fetch always raises ld_pc_dc together with ld_ir_dc, so the IR strobe
   // alone qualifies the capture.
   logic unused_ld_pc;
   assign unused_ld_pc = ld_pc_dc;

   instr_decoder #(.IW(IW), .DW(DW), .RW(RW)) u_dec (
      .ir        (ir_p0),
      .op        (d_op),
      .rx        (d_rx),
      .ry        (d_ry),
      .imm8      (d_imm8),
      .imm11     (d_imm11),
      .uses_rx   (d_uses_rx),
      .uses_ry   (d_uses_ry),
      .writes_rx (d_writes_rx),
      .is_sjump  (d_is_sjump),
      .is_rjump  (d_is_rjump),
      .issues_ex (d_issues_ex),
      .illegal   (d_illegal)
   );

   always_comb begin
      ld_use = (ex_op == OP_LD) &&
               ((d_uses_rx && (d_rx == ex_rx)) || (d_uses_ry && (d_ry == ex_rx)));
      // Register jumps read rx in DC, so any in-flight writer of rx blocks them;
      // ex_rx already holds the link register for calls.
      jr_dep = d_is_rjump && ex_writes && (ex_rx == d_rx);
      hazard = vld_p0 && ex_valid && (ld_use || jr_dep);
   end

   assign ex_open  = !ex_valid || ex_ready;
   assign advance  = vld_p0 && !hazard && ex_open;
   assign dc_stall = vld_p0 && !advance;
   assign s_jump   = advance && d_is_sjump;
   assign r_jump   = advance && d_is_rjump;
   assign jmp_imm  = d_imm11;
   assign jmp_reg  = d_rx;

   assign is_call   = (d_op == OP_CALL) || (d_op == OP_CALLR);
   assign ex_rx_nxt = is_call ? RW'(LINK_REG) : d_rx;

   always_comb begin
      ex_imm_nxt = '0;
      if (d_op == OP_MVI) ex_imm_nxt = d_imm8;
      else if (is_call)   ex_imm_nxt = pc_p0 + DW'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         vld_p0     <= 1'b0;
         pc_p0      <= '0;
         ir_p0      <= '0;
         ex_valid   <= 1'b0;
         ex_writes  <= 1'b0;
         ex_op      <= '0;
         ex_rx      <= '0;
         ex_ry      <= '0;
         ex_imm     <= '0;
         ex_pc      <= '0;
         illegal    <= 1'b0;
         bubble_cnt <= '0;
      end else begin
         // DC slot: refill when empty or advancing; a jump squashes the wrong path.
         if (!vld_p0 || advance) begin
            if (s_jump || r_jump) begin
               vld_p0 <= 1'b0;
            end else if (ld_ir_dc) begin
               vld_p0 <= 1'b1;
               pc_p0  <= pc_in;
               ir_p0  <= ir_in;
            end else begin
               vld_p0 <= 1'b0;
            end
         end
         // EX register (stage p1)
         if (ex_open) begin
            ex_valid  <= advance && d_issues_ex;
            ex_writes <= d_writes_rx;
            ex_op     <= d_op;
            ex_rx     <= ex_rx_nxt;
            ex_ry     <= d_ry;
            ex_imm    <= ex_imm_nxt;
            ex_pc     <= pc_p0;
         end
         illegal <= advance && d_illegal;
         if (hazard && ex_open && (bubble_cnt != 16'hFFFF))
            bubble_cnt <= bubble_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        reset, ld_pc_dc, ld_ir_dc, ex_ready;
   logic [15:0] pc_in, ir_in;
   logic        r_jump, s_jump, dc_stall, ex_valid, illegal;
   logic [15:0] jmp_imm, ex_imm, ex_pc, bubble_cnt;
   logic [2:0]  jmp_reg, ex_rx, ex_ry;
   logic [4:0]  ex_op;

   int checks = 0;
   int failures = 0;
   bit chk_en = 0;

   // Reference model state
   logic        m_dv, m_ev, m_ill;
   logic [15:0] m_dpc, m_dir, m_eimm, m_epc;
   logic [4:0]  m_eop;
   logic [2:0]  m_erx, m_ery;
   int          m_bub;

   always #5 clk = ~clk;

   decode_stage dut (
      .clk(clk), .reset(reset), .ld_pc_dc(ld_pc_dc), .ld_ir_dc(ld_ir_dc),
      .pc_in(pc_in), .ir_in(ir_in), .ex_ready(ex_ready),
      .r_jump(r_jump), .s_jump(s_jump), .jmp_imm(jmp_imm), .jmp_reg(jmp_reg),
      .dc_stall(dc_stall), .ex_valid(ex_valid), .ex_op(ex_op), .ex_rx(ex_rx),
      .ex_ry(ex_ry), .ex_imm(ex_imm), .ex_pc(ex_pc), .illegal(illegal),
      .bubble_cnt(bubble_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] src_mask(input logic [15:0] ir);
      logic [7:0] m;
      int op, rx, ry;
      m = '0; op = int'(ir[15:11]); rx = int'(ir[10:8]); ry = int'(ir[7:5]);
      if (op inside {1, 2, 3, 4, 6}) begin m[rx] = 1'b1; m[ry] = 1'b1; end
      else if (op == 5)              m[ry] = 1'b1;
      else if (op == 9 || op == 11)  m[rx] = 1'b1;
      return m;
   endfunction

   function automatic bit writes(input int op);
      return op inside {1, 2, 3, 4, 5, 7, 10, 11};
   endfunction

   function automatic logic [15:0] sext(input int v, input int bits);
      int r;
      r = v;
      if (r >= (1 << (bits - 1))) r = r - (1 << bits);
      return r[15:0];
   endfunction

   task automatic model_zero();
      m_dv = 0; m_dpc = 0; m_dir = 0; m_ev = 0; m_eop = 0; m_erx = 0;
      m_ery = 0; m_eimm = 0; m_epc = 0; m_ill = 0; m_bub = 0;
   endtask

   // Compare DUT with the model for the current cycle, then advance the model.
   task automatic model_cycle();
      int op, rx, eop;
      logic [7:0] mask;
      bit haz, open, adv, js, jr, call;
      op = int'(m_dir[15:11]); rx = int'(m_dir[10:8]); eop = int'(m_eop);
      mask = src_mask(m_dir);
      haz  = m_dv && m_ev && ((eop == 5 && mask[m_erx]) ||
                              ((op == 9 || op == 11) && writes(eop) && int'(m_erx) == rx));
      open = !m_ev || ex_ready;
      adv  = m_dv && !haz && open;
      js   = adv && (op == 8 || op == 10);
      jr   = adv && (op == 9 || op == 11);
      call = (op == 10 || op == 11);
      if (chk_en) begin
         chk("s_jump",     32'(s_jump),     32'(js));
         chk("r_jump",     32'(r_jump),     32'(jr));
         chk("dc_stall",   32'(dc_stall),   32'(m_dv && !adv));
         chk("jmp_imm",    32'(jmp_imm),    32'(sext(int'(m_dir[10:0]), 11)));
         chk("jmp_reg",    32'(jmp_reg),    32'(rx));
         chk("ex_valid",   32'(ex_valid),   32'(m_ev));
         chk("ex_op",      32'(ex_op),      32'(m_eop));
         chk("ex_rx",      32'(ex_rx),      32'(m_erx));
         chk("ex_ry",      32'(ex_ry),      32'(m_ery));
         chk("ex_imm",     32'(ex_imm),     32'(m_eimm));
         chk("ex_pc",      32'(ex_pc),      32'(m_epc));
         chk("illegal",    32'(illegal),    32'(m_ill));
         chk("bubble_cnt", 32'(bubble_cnt), 32'(m_bub));
      end
      if (!reset) begin
         model_zero();
      end else begin
         if (open) begin
            m_ev   = adv && (op inside {[1:7], 10, 11});
            m_eop  = m_dir[15:11];
            m_erx  = call ? 3'd7 : m_dir[10:8];
            m_ery  = m_dir[7:5];
            m_eimm = (op == 7) ? sext(int'(m_dir[7:0]), 8) : call ? m_dpc + 16'd1 : 16'd0;
            m_epc  = m_dpc;
         end
         m_ill = adv && (op > 11);
         if (haz && open && m_bub < 65535) m_bub++;
         if (!m_dv || adv) begin
            if (js || jr) m_dv = 0;
            else if (ld_ir_dc) begin m_dv = 1; m_dpc = pc_in; m_dir = ir_in; end
            else m_dv = 0;
         end
      end
   endtask

   task automatic cycle();
      #1;
      model_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [15:0] ir, input logic [15:0] pc);
      ld_ir_dc = 1; ld_pc_dc = 1; ir_in = ir; pc_in = pc;
   endtask

   task automatic idle();
      ld_ir_dc = 0; ld_pc_dc = 0;
   endtask

   initial begin
      // Reset held for two edges while fetch offers ADD r1,r2.
      reset = 0; ex_ready = 1; offer(16'h0940, 16'h0010);
      model_zero();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ex_valid", 32'(ex_valid), 32'd0);
      chk("rst_ex_op",    32'(ex_op),    32'd0);
      chk("rst_ex_imm",   32'(ex_imm),   32'd0);
      chk("rst_ex_pc",    32'(ex_pc),    32'd0);
      chk("rst_illegal",  32'(illegal),  32'd0);
      chk("rst_bubble",   32'(bubble_cnt), 32'd0);
      chk("rst_s_jump",   32'(s_jump),   32'd0);
      chk("rst_r_jump",   32'(r_jump),   32'd0);
      chk("rst_dc_stall", 32'(dc_stall), 32'd0);
      chk("rst_jmp_imm",  32'(jmp_imm),  32'd0);
      chk_en = 1;

      // ALU issue
      reset = 1; offer(16'h0940, 16'h0010); cycle();
      idle(); cycle();
      chk("alu_valid", 32'(ex_valid), 32'd1);
      chk("alu_op",    32'(ex_op),    32'h01);
      chk("alu_rx",    32'(ex_rx),    32'd1);
      chk("alu_ry",    32'(ex_ry),    32'd2);
      chk("alu_pc",    32'(ex_pc),    32'h0010);

      // Load-use: LD r3,[r4] then ADD r5,r3
      offer(16'h2B80, 16'h0011); cycle();
      offer(16'h0D60, 16'h0012); cycle();
      idle(); #1;
      chk("lu_stall", 32'(dc_stall), 32'd1);
      cycle();
      chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
      chk("lu_bubble_cnt",   32'(bubble_cnt), 32'd1);
      #1;
      chk("lu_unstall", 32'(dc_stall), 32'd0);
      cycle();
      chk("lu_add_op", 32'(ex_op), 32'h01);
      chk("lu_add_rx", 32'(ex_rx), 32'd5);
      chk("lu_cnt",    32'(bubble_cnt), 32'd1);

      // Immediate jump with a wrong-path instruction offered behind it
      offer(16'h47F0, 16'h0040); cycle();
      offer(16'h0940, 16'h0041); #1;
      chk("j_s_jump", 32'(s_jump), 32'd1);
      chk("j_imm",    32'(jmp_imm), 32'hFFF0);
      chk("j_r_jump", 32'(r_jump), 32'd0);
      cycle();
      idle(); #1;
      chk("j_squash_stall", 32'(dc_stall), 32'd0);
      chk("j_squash_sj",    32'(s_jump),   32'd0);
      chk("j_no_issue",     32'(ex_valid), 32'd0);
      cycle();
      chk("j_empty", 32'(ex_valid), 32'd0);

      // Back-pressure: MVI r2,#0x85 in EX, CALL in DC, execute not ready
      offer(16'h3A85, 16'h0050); cycle();
      offer(16'h5005, 16'h0030); cycle();
      idle(); ex_ready = 0; #1;
      chk("bp_stall", 32'(dc_stall), 32'd1);
      chk("bp_sjump", 32'(s_jump),   32'd0);
      repeat (3) cycle();
      chk("bp_valid", 32'(ex_valid), 32'd1);
      chk("bp_op",    32'(ex_op),    32'h07);
      chk("bp_rx",    32'(ex_rx),    32'd2);
      chk("bp_imm",   32'(ex_imm),   32'hFF85);
      ex_ready = 1; #1;
      chk("bp_release_sjump", 32'(s_jump), 32'd1);
      cycle();
      chk("bp_sjump_once", 32'(s_jump), 32'd0);
      chk("call_op",  32'(ex_op),  32'h0A);
      chk("call_rx",  32'(ex_rx),  32'd7);
      chk("call_imm", 32'(ex_imm), 32'h0031);

      // Register call
      offer(16'h5E00, 16'h0020); cycle();
      idle(); #1;
      chk("callr_rjump", 32'(r_jump),  32'd1);
      chk("callr_reg",   32'(jmp_reg), 32'd6);
      cycle();
      chk("callr_op",  32'(ex_op),  32'h0B);
      chk("callr_rx",  32'(ex_rx),  32'd7);
      chk("callr_imm", 32'(ex_imm), 32'h0021);

      // JR r7 behind CALLR (writes r7): jump-register hazard
      ex_ready = 0; offer(16'h4F00, 16'h0060); cycle();
      idle(); #1;
      chk("jr_haz_stall", 32'(dc_stall), 32'd1);
      chk("jr_haz_rjump", 32'(r_jump),   32'd0);
      ex_ready = 1; cycle();
      chk("jr_bubble", 32'(bubble_cnt), 32'd2);
      #1;
      chk("jr_go", 32'(r_jump), 32'd1);
      cycle();

      // Reset overrides an in-flight jump
      offer(16'h47F0, 16'h0070); cycle();
      idle(); reset = 0; #1;
      chk("mr_sjump_pre", 32'(s_jump), 32'd1);
      cycle();
      reset = 1; #1;
      chk("mr_sjump",  32'(s_jump),     32'd0);
      chk("mr_stall",  32'(dc_stall),   32'd0);
      chk("mr_bubble", 32'(bubble_cnt), 32'd0);

      // Randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         logic [4:0] op;
         logic [2:0] rx, ry;
         reset    = ($urandom_range(0, 99) != 0);
         ld_ir_dc = ($urandom_range(0, 3) != 0);
         ld_pc_dc = ld_ir_dc;
         ex_ready = ($urandom_range(0, 3) != 0);
         op = ($urandom_range(0, 19) == 0) ? 5'($urandom_range(12, 31)) : 5'($urandom_range(0, 11));
         rx = ($urandom_range(0, 4) == 0) ? 3'd7 : 3'($urandom_range(0, 3));
         ry = 3'($urandom_range(0, 3));
         ir_in = {op, rx, ry, 5'($urandom)};
         pc_in = 16'($urandom);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
# decode_stage

Decode stage of the pipelined CPU, directly downstream of the fetch controller. Captures the PC/IR pair that fetch hands over via `ld_pc_dc`/`ld_ir_dc` and decodes it. It generates the `r_jump`/`s_jump` requests that fetch consumes, detects load-use and jump-register hazards, and issues decoded operations into a valid/ready register toward execute.

## Interface
- `IW`, 16: instruction width.
- `DW`, 16: PC/data width.
- `RW`, 3: register index width (8 registers).
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-low reset (0 = reset), sampled on `clk` rising edge.
- `ld_pc_dc` in 1: fetch offers a PC this cycle.
- `ld_ir_dc` in 1: fetch offers an instruction this cycle.
- `pc_in` in DW: PC of the offered instruction.
- `ir_in` in IW: offered instruction.
- `ex_ready` in 1: execute accepts the EX register this cycle.
- `r_jump` out 1: register-target jump/call issuing this cycle.
- `s_jump` out 1: immediate-target jump/call issuing this cycle.
- `jmp_imm` out DW: sign-extended imm11 of the DC instruction.
- `jmp_reg` out RW: rx of the DC instruction; this is the register-file read index for the jump target.
- `dc_stall` out 1: DC instruction cannot advance; the top level gates fetch `ld_pc` with this.
- `ex_valid` out 1: EX register holds an operation.
- `ex_op` out 5: opcode.
- `ex_rx` out RW: rx field.
- `ex_ry` out RW: ry field.
- `ex_imm` out DW: immediate or link value.
- `ex_pc` out DW: PC of the operation.
- `illegal` out 1: one-cycle pulse when an undefined opcode advances.
- `bubble_cnt` out 16: saturating count of hazard bubbles.

## Operation
- **Instruction fields**
  - op = IR[15:11], rx = IR[10:8], ry = IR[7:5].
  - imm11 = IR[10:0], imm8 = IR[7:0]; both are sign-extended to DW.
- **Opcodes:** NOP=00, ADD=01, SUB=02, AND=03, OR=04, LD=05, ST=06, MVI=07, J=08, JR=09, CALL=0A, CALLR=0B. All others are illegal and behave as NOP.
- **Source registers per opcode**
  - ALU ops (ADD, SUB, AND, OR): rx, ry.
  - LD: ry.
  - ST: rx, ry.
  - JR, CALLR: rx.
  - MVI, J, CALL, NOP: none.
- **Writers (opcodes that write a register):** ALU ops, LD, MVI, CALL, CALLR.
- **DC register** holds `dc_valid`, `dc_pc`, `dc_ir`.
- **Hazard** is asserted when `dc_valid` and `ex_valid` are both set and either of these holds:
  - `ex_op`=LD and `ex_rx` equals a DC source register;
  - the DC op is JR or CALLR, `ex_op` is a writer, and `ex_rx` (7 for calls) equals DC rx.
- **Advance** = `dc_valid` & !hazard & (!`ex_valid` | `ex_ready`).
- **Stall:** `dc_stall` = `dc_valid` & !advance.
- **Jump outputs**
  - `s_jump` = advance & op∈{J, CALL}.
  - `r_jump` = advance & op∈{JR, CALLR}.
  - Both are combinational from the DC register. They are never asserted together and never asserted while stalled.
- **DC register update**, when !`dc_valid` or advance:
  - if a jump issues this cycle, `dc_valid`←0 (squash the wrong path);
  - else if `ld_ir_dc`, capture `pc_in`/`ir_in` and set `dc_valid`←1;
  - else `dc_valid`←0.
  - Under stall the DC register holds and ignores the `ld_*` inputs.
- **EX register update**, when !`ex_valid` or `ex_ready`:
  - `ex_valid`←advance & op∉{NOP, J, JR, illegal};
  - fields load from the DC register;
  - `ex_imm` = sext(imm8) for MVI; `dc_pc`+1 (link value) for CALL and CALLR; 0 otherwise;
  - `ex_rx` = 7 for CALL and CALLR.
  - Otherwise the EX register holds all fields unchanged.
- **Bubble counter:** `bubble_cnt` increments on every cycle with hazard & (!`ex_valid` | `ex_ready`), which produces a bubble into execute. It saturates at 16'hFFFF.
- **Reset** (`reset`=0) clears `dc_valid`, `ex_valid`, all EX fields, `illegal`, and `bubble_cnt`. All outputs read 0 in the cycle after reset, including `r_jump`, `s_jump`, and `dc_stall`.
- **Mid-operation reset:** reset overrides every event in the same cycle, including an in-flight jump.

## Timing
- **DC → EX latency:** 1 cycle. An instruction captured at edge N appears on `ex_*` after edge N+1 if it is not stalled.
- **Jump timing:** `r_jump`/`s_jump` are valid in the same cycle as the advancing instruction. Fetch loads the new PC at the following edge.
- **Squash:** the DC slot is empty for exactly one cycle after a jump.
- **Load-use:** costs exactly one bubble; `dc_stall` is high for one cycle when `ex_ready`=1.
- **Back-pressure:** while `ex_valid` & !`ex_ready`, all `ex_*` outputs are stable and `dc_stall` is high for any valid DC instruction.
- **Simultaneous hazard and `ex_ready`=0:** the design holds; no bubble is counted until `ex_ready`=1.

## Structure
- **`cpu_pkg`** (shared package) contains:
  - the opcode enum `opcode_e`;
  - field position localparams;
  - `LINK_REG`=7.
- **`instr_decoder`** (combinational sub-module) takes an IR and produces:
  - op, rx, ry, and the sign-extended imm8/imm11;
  - the flags `uses_rx`, `uses_ry`, `writes_rx`, `is_sjump`, `is_rjump`, `issues_ex`, `illegal`.
- **`decode_stage`** owns the registers, the hazard logic, and the handshake.

## Test plan
- **Reset:** hold `reset`=0 for 2 cycles with `ld_ir_dc`=1 and `ir_in`=16'h0940 → all outputs 0, `bubble_cnt`=0.
- **ALU issue:** ADD r1,r2 (16'h0940) with `pc_in`=16'h0010 and `ex_ready`=1 → one cycle later `ex_valid`=1, `ex_op`=01, `ex_rx`=1, `ex_ry`=2, `ex_pc`=16'h0010.
- **Load-use:** LD r3,[r4] (16'h2B80) followed by ADD r5,r3 (16'h0D60) → `dc_stall`=1 for one cycle, one `ex_valid`=0 bubble, then the ADD issues; `bubble_cnt`=1.
- **Immediate jump:** J imm11=0x7F0 (16'h47F0) → `s_jump`=1 for one cycle, `jmp_imm`=16'hFFF0, no EX issue, DC slot empty next cycle.
- **Back-pressure:** `ex_ready`=0 with `ex_valid`=1 and a CALL in DC → `ex_*` stable, `dc_stall`=1, `s_jump`=0; when `ex_ready`=1, `s_jump` pulses once.
- **Register call:** CALLR r6 (16'h5E00) at `pc_in`=16'h0020 → `r_jump`=1, `jmp_reg`=6; next cycle `ex_op`=0B, `ex_rx`=7, `ex_imm`=16'h0021.
